// File: rtl/unrank_pkg.sv
// Shared definitions for the combinadic unranker: constant binomial helpers,
// the maximum-rank computation and the FSM state type.
package unrank_pkg;

  typedef enum logic [0:0] {IDLE, EMIT} state_e;

  // Elaboration-time factorial; overflows above 20!.
  function automatic longint unsigned fact(input int unsigned n);
    longint unsigned res;
    res = 1;
    for (int unsigned i = 2; i <= n; i++) res = res * longint'(i);
    return res;
  endfunction

  // Elaboration-time C(n,k). Multiplicative form keeps every partial product
  // exact and avoids the factorial overflow. C(n,k) = 0 for k > n.
  function automatic longint unsigned binom(input int unsigned n, input int unsigned k);
    longint unsigned res;
    if (k > n) return 0;
    res = 1;
    for (int unsigned i = 0; i < k; i++) res = res * longint'(n - i) / longint'(i + 1);
    return res;
  endfunction

  // Number of K-combinations of n rows; valid ranks are 0..max_rank-1.
  function automatic longint unsigned max_rank(input int unsigned n, input int unsigned k);
    return binom(n, k);
  endfunction

endpackage

// File: rtl/tcol.sv
// Binomial column search for one column k = COL_INDEX.
// Ports:
//   num - value to search against
//   row - highest row c in 0..ROWS_NUM-1 with C(c,k) <= num
//   val - C(row,k)
module tcol
  import unrank_pkg::*;
#(
  parameter int unsigned COL_INDEX   = 1,
  parameter int unsigned NUM_WIDTH   = 10,
  parameter int unsigned ROWS_NUM    = 13,
  parameter int unsigned VALUE_WIDTH = 10,
  parameter int unsigned ROW_WIDTH   = 4
) (
  input  logic [NUM_WIDTH-1:0]   num,
  output logic [ROW_WIDTH-1:0]   row,
  output logic [VALUE_WIDTH-1:0] val
);

  logic [VALUE_WIDTH-1:0] coef [ROWS_NUM];
  logic [VALUE_WIDTH-1:0] num_ext;

  assign num_ext = VALUE_WIDTH'(num);

  for (genvar c = 0; c < ROWS_NUM; c++) begin : g_row
    assign coef[c] = VALUE_WIDTH'(binom(c, COL_INDEX));
  end

  // Coefficients are non-decreasing in c, so the last hit is the highest row.
  // Rows below COL_INDEX have C = 0 and always hit, so row >= COL_INDEX-1.
  always_comb begin
    row = '0;
    val = '0;
    for (int c = 0; c < ROWS_NUM; c++) begin
      if (coef[c] <= num_ext) begin
        row = ROW_WIDTH'(c);
        val = coef[c];
      end
    end
  end

endmodule

// File: rtl/unrank_seq.sv
// Sequential combinadic unranker. Takes a rank and streams the K elements of
// that K-combination of {0..ROWS_NUM-1}, largest first, one per beat.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid/in_ready/in_rank     - rank input handshake
//   out_valid/out_ready           - element output handshake
//   out_elem, out_last, out_err   - element, final-beat flag, out-of-range flag
module unrank_seq
  import unrank_pkg::*;
#(
  parameter int unsigned NUM_WIDTH   = 10,
  parameter int unsigned K           = 4,
  parameter int unsigned ROWS_NUM    = 13,
  parameter int unsigned VALUE_WIDTH = 10,
  parameter int unsigned ROW_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_WIDTH-1:0] in_rank,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROW_WIDTH-1:0] out_elem,
  output logic                 out_last,
  output logic                 out_err
);

  localparam int unsigned     KW      = $clog2(K + 1);
  localparam longint unsigned MAXRANK = max_rank(ROWS_NUM, K);

  state_e                 state_q, state_d;
  logic [ROW_WIDTH-1:0]   elem_q, elem_d;
  logic [NUM_WIDTH-1:0]   rem_q, rem_d;
  logic [KW-1:0]          k_q, k_d;
  logic                   last_q, last_d;
  logic                   err_q, err_d;

  logic [NUM_WIDTH-1:0]   num;
  logic [KW-1:0]          col_sel;
  logic [ROW_WIDTH-1:0]   col_row [1:K];
  logic [VALUE_WIDTH-1:0] col_val [1:K];
  logic [ROW_WIDTH-1:0]   row;
  logic [VALUE_WIDTH-1:0] val;
  logic [NUM_WIDTH-1:0]   val_n;
  logic                   rank_err;

  // IDLE searches the incoming rank in column K; EMIT continues on the remainder.
  assign num     = (state_q == IDLE) ? in_rank : rem_q;
  assign col_sel = (state_q == IDLE) ? KW'(K) : k_q;

  for (genvar k = 1; k <= K; k++) begin : g_col
    tcol #(
      .COL_INDEX  (k),
      .NUM_WIDTH  (NUM_WIDTH),
      .ROWS_NUM   (ROWS_NUM),
      .VALUE_WIDTH(VALUE_WIDTH),
      .ROW_WIDTH  (ROW_WIDTH)
    ) u_tcol (
      .num(num),
      .row(col_row[k]),
      .val(col_val[k])
    );
  end

  always_comb begin
    row = '0;
    val = '0;
    for (int unsigned k = 1; k <= K; k++) begin
      if (col_sel == KW'(k)) begin
        row = col_row[k];
        val = col_val[k];
      end
    end
  end

  // val <= num by construction, so it fits in NUM_WIDTH and never underflows.
  assign val_n    = NUM_WIDTH'(val);
  assign rank_err = 64'(in_rank) >= MAXRANK;

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    rem_d   = rem_q;
    k_d     = k_q;
    last_d  = last_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = EMIT;
          if (rank_err) begin
            elem_d = '0;
            err_d  = 1'b1;
            last_d = 1'b1;
          end else begin
            elem_d = row;
            rem_d  = num - val_n;
            k_d    = KW'(K - 1);
            err_d  = 1'b0;
            last_d = (K == 1);
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            elem_d = row;
            rem_d  = num - val_n;
            k_d    = k_q - KW'(1);
            last_d = (k_q == KW'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      elem_q  <= '0;
      rem_q   <= '0;
      k_q     <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      rem_q   <= rem_d;
      k_q     <= k_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_elem  = elem_q;
  assign out_last  = last_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_unrank_seq.sv
module tb_unrank_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] in_rank = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_elem;
  logic       out_last;
  logic       out_err;

  unrank_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rank  (in_rank),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_elem (out_elem),
    .out_last (out_last),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int elem;
    bit last;
    bit err;
  } beat_t;

  int          total = 0;
  int          bad   = 0;
  int unsigned pas [0:13][0:4];
  beat_t       mq [$];
  beat_t       exp_q [$];
  int          cap [$];
  bit          rnd_mode  = 1'b0;
  bit          after_rst = 1'b0;
  bit          stall_prev = 1'b0;
  logic [3:0]  prev_elem;
  logic        prev_last, prev_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Greedy combinadic decomposition from Pascal's triangle.
  function automatic void build(input int r);
    int rem;
    int c;
    mq.delete();
    if (r >= int'(pas[13][4])) begin
      mq.push_back('{elem: 0, last: 1'b1, err: 1'b1});
    end else begin
      rem = r;
      for (int k = 4; k >= 1; k--) begin
        c = 0;
        for (int x = 0; x < 13; x++) if (int'(pas[x][k]) <= rem) c = x;
        mq.push_back('{elem: c, last: (k == 1), err: 1'b0});
        rem -= int'(pas[c][k]);
      end
    end
  endfunction

  // Out-ready driver: always ready, or pseudo-random stalls.
  always @(posedge clk) begin
    #1;
    out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cap.delete();
      after_rst  = 1'b1;
      stall_prev = 1'b0;
    end else begin
      if (after_rst) begin
        chk("rst_elem", 32'(out_elem), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_err", 32'(out_err), 0);
        after_rst = 1'b0;
      end
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_elem", 32'(out_elem), 32'(prev_elem));
        chk("stall_last", 32'(out_last), 32'(prev_last));
        chk("stall_err", 32'(out_err), 32'(prev_err));
      end
      if (out_valid && exp_q.size() != 0) begin
        chk("elem", 32'(out_elem), 32'(exp_q[0].elem));
        chk("last", 32'(out_last), 32'(exp_q[0].last));
        chk("err", 32'(out_err), 32'(exp_q[0].err));
        if (out_ready) begin
          cap.push_back(int'(out_elem));
          void'(exp_q.pop_front());
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_elem  = out_elem;
      prev_last  = out_last;
      prev_err   = out_err;
      if (in_valid && in_ready) begin
        build(int'(in_rank));
        foreach (mq[i]) exp_q.push_back(mq[i]);
      end
    end
  end

  // Offer a rank and return just after it is accepted.
  task automatic send(input int r, input bit keep);
    int n = 0;
    in_valid = 1'b1;
    in_rank  = 10'(r);
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      bad++;
      total++;
      $display("FAIL accept_timeout: rank %0d not accepted, expected accept within 200", r);
    end
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  // Cycles (counted from the accept edge) until in_ready is seen high.
  task automatic wait_idle(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!in_ready && lat < 400);
    if (!in_ready) begin
      bad++;
      total++;
      $display("FAIL idle_timeout: in_ready low for %0d cycles, expected high", lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string name, input int off,
                           input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    chk({name, "_len"}, 32'(cap.size() >= off + 4), 1);
    for (int i = 0; i < 4; i++) begin
      if (off + i < cap.size()) chk($sformatf("%s_b%0d", name, i), 32'(cap[off+i]), 32'(e[i]));
    end
  endtask

  int lat;

  initial begin
    for (int n = 0; n <= 13; n++) begin
      pas[n][0] = 1;
      for (int k = 1; k <= 4; k++) pas[n][k] = (n == 0) ? 0 : pas[n-1][k-1] + pas[n-1][k];
    end
    chk("model_maxrank", pas[13][4], 715);
    build(100);
    chk("model_100_len", 32'(mq.size()), 4);
    chk("model_100_b0", 32'(mq[0].elem), 8);
    chk("model_100_b1", 32'(mq[1].elem), 6);
    chk("model_100_b2", 32'(mq[2].elem), 5);
    chk("model_100_b3", 32'(mq[3].elem), 0);
    build(715);
    chk("model_715_len", 32'(mq.size()), 1);
    chk("model_715_err", 32'(mq[0].err), 1);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    send(0, 1'b0);
    wait_idle(lat);
    chk("lat_rank0", 32'(lat), 5);
    check_seq("rank0", 0, 3, 2, 1, 0);
    cap.delete();

    send(100, 1'b0);
    wait_idle(lat);
    check_seq("rank100", 0, 8, 6, 5, 0);
    cap.delete();

    send(714, 1'b0);
    wait_idle(lat);
    check_seq("rank714", 0, 12, 11, 10, 9);
    cap.delete();

    send(715, 1'b0);
    wait_idle(lat);
    chk("lat_rank715", 32'(lat), 2);
    chk("rank715_len", 32'(cap.size()), 1);
    if (cap.size() > 0) chk("rank715_elem", 32'(cap[0]), 0);
    cap.delete();

    rnd_mode = 1'b1;
    send(100, 1'b0);
    wait_idle(lat);
    rnd_mode = 1'b0;
    check_seq("rank100_stall", 0, 8, 6, 5, 0);
    cap.delete();

    // Reset during the second beat of rank 714.
    send(714, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    send(0, 1'b0);
    wait_idle(lat);
    check_seq("after_rst", 0, 3, 2, 1, 0);
    cap.delete();

    send(1, 1'b1);
    send(2, 1'b1);
    send(3, 1'b0);
    wait_idle(lat);
    chk("b2b_len", 32'(cap.size()), 12);
    check_seq("b2b_r1", 0, 4, 2, 1, 0);
    check_seq("b2b_r2", 4, 4, 3, 1, 0);
    check_seq("b2b_r3", 8, 4, 3, 2, 0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unrank_seq.md
# unrank_seq

Sequential combinadic unranker. Accepts a rank `r` and streams the K elements of the r-th K-combination of `{0..ROWS_NUM-1}`, largest first, one element per handshake beat. It sits directly downstream of the rank source and drives the team's binomial column-search blocks. Each beat selects the highest row `c` with `C(c,k) <= remainder`, then subtracts that coefficient.

## Interface
Parameters:
- `NUM_WIDTH`, 10: width of rank and remainder.
- `K`, 4: combination size; columns `K..1` are used. Must satisfy `1 <= K <= ROWS_NUM`.
- `ROWS_NUM`, 13: n, the number of rows per column. Elements lie in `0..ROWS_NUM-1`.
- `VALUE_WIDTH`, 10: width of binomial values. Must be `>= NUM_WIDTH`.
- `ROW_WIDTH`, 4: element width. Must satisfy `ceil(log2(ROWS_NUM)) <= ROW_WIDTH`.

Ports:
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: rank offered.
- `in_ready` out 1: block can accept a rank.
- `in_rank` in NUM_WIDTH: rank to unrank.
- `out_valid` out 1: element beat valid.
- `out_ready` in 1: consumer accepts the beat.
- `out_elem` out ROW_WIDTH: combination element.
- `out_last` out 1: final beat of this rank.
- `out_err` out 1: rank out of range. Set only on a single-beat error response.

## Operation
- States: `IDLE` and `EMIT`. Registers: `elem_r`, `rem_r` (NUM_WIDTH), `k_r` (column of the next element), `last_r`, `err_r`.
- Search datapath: K column-search instances, one per column `k=1..K`, all fed from a shared `num`.
  - In `IDLE`, `num = in_rank` and column K is selected.
  - In `EMIT`, `num = rem_r` and column `k_r` is selected.
  - The search yields `(row, val)`.
- Range check: `MAXRANK = C(ROWS_NUM,K)` is an elaboration-time constant. A rank with `in_rank >= MAXRANK` is an error.
- `IDLE`:
  - `in_ready = 1`.
  - On `in_valid & in_ready`:
    - Error rank: `elem_r=0`, `err_r=1`, `last_r=1`.
    - Valid rank: `elem_r=row`, `rem_r=in_rank-val`, `k_r=K-1`, `err_r=0`, `last_r=(K==1)`.
  - Next state is `EMIT`.
- `EMIT`:
  - `out_valid=1`, `in_ready=0`.
  - Outputs are driven from registers: `out_elem=elem_r`, `out_last=last_r`, `out_err=err_r`.
  - On `out_ready` with `last_r=0`: `elem_r=row`, `rem_r=rem_r-val`, `k_r=k_r-1`, `last_r=(k_r==1)`.
  - On `out_ready` with `last_r=1`: go to `IDLE`.
  - While `out_ready=0`: all registers hold and the outputs stay stable.
- Arithmetic: the subtraction is unsigned and never underflows, since `val <= num` by construction. When the remainder is 0 at column k, the element is `k-1`. Emitted elements are strictly decreasing.
- Reset: `rst` in any state forces `IDLE`. All output registers go to 0 at reset: `out_valid=0`, `out_elem=0`, `out_last=0`, `out_err=0`. After reset `in_ready=1`. An in-flight combination is discarded with no partial completion.

## Timing
- Rank accepted at cycle t produces the first beat with `out_valid=1` at t+1.
- With `out_ready` held high, the K beats occupy cycles t+1..t+K.
- `in_ready` returns at t+K+1. There is no accept in the same cycle as the last beat.
- Throughput is one rank per K+1 cycles.
- The combinational path is a K-way column mux, then row compare/encode, then subtract. There is one register stage.
- Back-pressure holds the current beat indefinitely. The outputs satisfy valid/ready stability rules.

## Structure
- Shared package `unrank_pkg`:
  - `fact`/`binom` constant functions.
  - `MAXRANK` computation.
  - state enum `{IDLE, EMIT}`.
- Sub-module: one column-search instance (`tcol`, with `COL_INDEX=k`) per column, generated for `k=1..K`. The per-column `row`/`val` outputs are muxed by the selected column.
- Top-level contents: FSM, remainder datapath, output registers.

## Test plan
- Defaults, rank 0 with `out_ready=1`: beats 3,2,1,0. `out_last` only on 0, `out_err=0`, `in_ready` high 5 cycles after accept.
- Rank 100: beats 8,6,5,0 (remainders 30, 10, 0, 0).
- Rank 714: beats 12,11,10,9. Rank 715: single beat with `elem=0`, `err=1`, `last=1`, and `in_ready` returns 2 cycles after accept.
- Rank 100 with `out_ready` toggling 0/1 pseudo-randomly: same sequence 8,6,5,0. Outputs are stable during every stall cycle.
- `rst` pulsed during the 2nd beat of rank 714: next cycle `out_valid=0`, all outputs 0, `in_ready=1`. A subsequent rank 0 yields 3,2,1,0.
- Back-to-back `in_valid` with ranks 1, 2, 3: beat sequences {4,2,1,0}, {4,3,1,0}, {4,3,2,0}. Each rank is accepted only while `in_ready=1`.
